// File: rtl/eq_band_gain_if.sv
// eq_band_gain_if: sample/gain bus between the upstream FIR and the per-band gain stage.
//   master modport : sample/gain producer (drives data_in, data_valid, gain_target, gain_load)
//   slave modport  : gain stage (drives data_out, out_valid, clip, gain_current, ramping, clip_count)
// Signals:
//   data_in      signed filtered sample           data_valid  data_in valid this cycle
//   gain_target  requested unsigned gain code     gain_load   latch gain_target this cycle
//   data_out     signed gained/rounded/saturated  out_valid   data_out valid this cycle
//   clip         data_out was saturated           gain_current gain code currently applied
//   ramping      gain_current != target           clip_count  saturation event counter
interface eq_band_gain_if #(
  parameter int unsigned word_size_in  = 16,
  parameter int unsigned word_size_out = 16,
  parameter int unsigned gain_width    = 8
);
  localparam int unsigned cnt_w = 16;

  logic signed [word_size_in-1:0]  data_in;
  logic                            data_valid;
  logic        [gain_width-1:0]    gain_target;
  logic                            gain_load;
  logic signed [word_size_out-1:0] data_out;
  logic                            out_valid;
  logic                            clip;
  logic        [gain_width-1:0]    gain_current;
  logic                            ramping;
  logic        [cnt_w-1:0]         clip_count;

  modport master (
    output data_in, data_valid, gain_target, gain_load,
    input  data_out, out_valid, clip, gain_current, ramping, clip_count
  );

  modport slave (
    input  data_in, data_valid, gain_target, gain_load,
    output data_out, out_valid, clip, gain_current, ramping, clip_count
  );
endinterface

// File: rtl/eq_band_gain.sv
// eq_band_gain: per-band gain stage after the low-pass FIR. Multiplies each signed
// sample by an unsigned fixed-point gain that ramps one LSB per valid sample toward
// a programmable target, then rounds (half toward +inf) and saturates to the output
// width. Two-stage valid-tagged pipeline, one sample per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    eq_band_gain_if.slave (sample in, gain control, result and status out)
// Optional feature: define EQ_GAIN_CLIP_COUNT_EN to enable the saturating clip event
// counter on clip_count; otherwise clip_count is tied to zero.
module eq_band_gain #(
  parameter int unsigned word_size_in  = 16,
  parameter int unsigned word_size_out = 16,
  parameter int unsigned gain_width    = 8,
  parameter int unsigned gain_frac     = 4
) (
  input  logic          clk,
  input  logic          reset,
  eq_band_gain_if.slave bus
);

  localparam int unsigned prod_w     = word_size_in + gain_width + 1;
  localparam int unsigned cnt_w      = 16;
  localparam int unsigned round_half = 1 << (gain_frac - 1);
  localparam int          sat_max_i  = (1 << (word_size_out - 1)) - 1;
  localparam int          sat_min_i  = -(1 << (word_size_out - 1));

  localparam logic [gain_width-1:0]    gain_unity = gain_width'(1 << gain_frac);
  localparam logic signed [prod_w-1:0] sat_max    = prod_w'(sat_max_i);
  localparam logic signed [prod_w-1:0] sat_min    = prod_w'(sat_min_i);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } state_t;

  // Gain control registers
  state_t                  r_state;
  logic [gain_width-1:0]   r_target;
  logic [gain_width-1:0]   r_gain;
  logic                    r_ramping;

  // Datapath registers
  logic signed [prod_w-1:0]        r_prod;
  logic                            r_v1;
  logic                            r_v2;
  logic signed [word_size_out-1:0] r_data_out;
  logic                            r_clip;

  // Combinational nets
  state_t                          w_state_next;
  logic [gain_width-1:0]           w_target_next;
  logic [gain_width-1:0]           w_gain_next;
  logic signed [word_size_in-1:0]  w_data_s;
  logic signed [gain_width:0]      w_gain_s;
  logic signed [prod_w-1:0]        w_prod;
  logic signed [prod_w-1:0]        w_rounded;
  logic signed [prod_w-1:0]        w_shifted;
  logic                            w_sat_hi;
  logic                            w_sat_lo;
  logic signed [word_size_out-1:0] w_data_sat;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: direction of the post-edge gain relative to the post-edge target,
  // so r_state always describes the registers visible in the current cycle.
  always_comb begin
    w_target_next = r_target;
    w_state_next  = ST_HOLD;
    if (bus.gain_load) begin
      w_target_next = bus.gain_target;
    end
    if (w_gain_next < w_target_next) begin
      w_state_next = ST_RAMP_UP;
    end else if (w_gain_next > w_target_next) begin
      w_state_next = ST_RAMP_DOWN;
    end
  end

  // FSM output: one-LSB gain step, only on valid samples. A load in the same cycle
  // does not influence this step because r_state reflects the old target.
  always_comb begin
    w_gain_next = r_gain;
    if (bus.data_valid) begin
      case (r_state)
        ST_RAMP_UP:   w_gain_next = r_gain + gain_width'(1);
        ST_RAMP_DOWN: w_gain_next = r_gain - gain_width'(1);
        default:      w_gain_next = r_gain;
      endcase
    end
  end

  // Gain, target and ramping flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target  <= gain_unity;
      r_gain    <= gain_unity;
      r_ramping <= 1'b0;
    end else begin
      r_target  <= w_target_next;
      r_gain    <= w_gain_next;
      r_ramping <= (w_state_next != ST_HOLD);
    end
  end

  // Stage 1 product uses the pre-step gain; gain is zero-extended to stay positive
  assign w_data_s = bus.data_in;
  assign w_gain_s = $signed({1'b0, r_gain});
  assign w_prod   = prod_w'(w_data_s) * prod_w'(w_gain_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= bus.data_valid;
      if (bus.data_valid) begin
        r_prod <= w_prod;
      end
    end
  end

  // Stage 2: round half toward +inf, drop fraction bits, saturate
  assign w_rounded  = r_prod + $signed(prod_w'(round_half));
  assign w_shifted  = w_rounded >>> gain_frac;
  assign w_sat_hi   = (w_shifted > sat_max);
  assign w_sat_lo   = (w_shifted < sat_min);
  assign w_data_sat = w_sat_hi ? word_size_out'(sat_max) :
                      w_sat_lo ? word_size_out'(sat_min) :
                                 w_shifted[word_size_out-1:0];

  // Output register; data_out and clip hold while no valid result arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2       <= 1'b0;
      r_data_out <= '0;
      r_clip     <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data_out <= w_data_sat;
        r_clip     <= w_sat_hi | w_sat_lo;
      end
    end
  end

`ifdef EQ_GAIN_CLIP_COUNT_EN
  logic [cnt_w-1:0] r_clip_count;

  // Count presented clipped results; sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clip_count <= '0;
    end else if (r_v2 && r_clip && (r_clip_count != {cnt_w{1'b1}})) begin
      r_clip_count <= r_clip_count + cnt_w'(1);
    end
  end

  assign bus.clip_count = r_clip_count;
`else
  assign bus.clip_count = {cnt_w{1'b0}};
`endif

  assign bus.data_out     = r_data_out;
  assign bus.out_valid    = r_v2;
  assign bus.clip         = r_clip;
  assign bus.gain_current = r_gain;
  assign bus.ramping      = r_ramping;

endmodule

// File: tb/tb_eq_band_gain.sv
// tb_eq_band_gain: directed scoreboard bench for eq_band_gain. Stimulus pushes the
// hand-computed result of each sample; an independent monitor pops on out_valid.
module tb_eq_band_gain;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  eq_band_gain_if bus ();

  eq_band_gain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef EQ_GAIN_CLIP_COUNT_EN
  localparam int exp_clip_count = 3;
`else
  localparam int exp_clip_count = 0;
`endif

  typedef struct {
    int data;
    bit clip;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Outputs for data_in=100 as gain ramps 16..32: floor((100*g + 8) / 16)
  int ramp_exp [17] = '{100, 106, 113, 119, 125, 131, 138, 144, 150,
                        156, 163, 169, 175, 181, 188, 194, 200};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue one sample (optionally with a coincident gain load) and queue its result
  task automatic send(input int d, input int ed, input bit ec,
                      input bit ld = 1'b0, input int tgt = 0);
    exp_t e;
    bus.data_in     = 16'(d);
    bus.data_valid  = 1'b1;
    bus.gain_load   = ld;
    bus.gain_target = 8'(tgt);
    e.data = ed;
    e.clip = ec;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.data_valid = 1'b0;
    bus.gain_load  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_tgt(input int tgt);
    bus.data_valid  = 1'b0;
    bus.gain_load   = 1'b1;
    bus.gain_target = 8'(tgt);
    @(posedge clk); #1;
    bus.gain_load   = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic drain(input string name);
    int k;
    k = 0;
    bus.data_valid = 1'b0;
    bus.gain_load  = 1'b0;
    while (sb_q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  // Monitor: compare every presented result against the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && bus.out_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_out: got data %0d with empty scoreboard", bus.data_out);
      end else begin
        e = sb_q.pop_front();
        if (int'(bus.data_out) == e.data && bus.clip == e.clip) n_pass++;
        else $display("FAIL out_sample: got data %0d clip %0d expected data %0d clip %0d",
                      bus.data_out, bus.clip, e.data, e.clip);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.data_in     = '0;
    bus.data_valid  = 1'b0;
    bus.gain_load   = 1'b0;
    bus.gain_target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_gain", bus.gain_current, 16);
    chk("rst_ramping", bus.ramping, 0);
    chk("rst_clip", bus.clip, 0);
    chk("rst_clip_count", bus.clip_count, 0);
    reset = 1'b0;
    idle(2);
    chk("idle_out_valid", bus.out_valid, 0);

    // Unity gain, two-cycle latency, then back-to-back samples
    send(1000, 1000, 1'b0);
    bus.data_valid = 1'b0;
    chk("lat_t1_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", bus.out_valid, 1);
    drain("drain_unity_a");
    send(-1000, -1000, 1'b0);
    send(7, 7, 1'b0);
    drain("drain_unity_b");

    // Ramp up to 32 with a gap in data_valid
    load_tgt(32);
    chk("ramp_start_gain", bus.gain_current, 16);
    chk("ramp_start_ramping", bus.ramping, 1);
    for (int i = 0; i < 8; i++) send(100, ramp_exp[i], 1'b0);
    idle(3);
    chk("gap_gain_frozen", bus.gain_current, 24);
    chk("gap_ramping", bus.ramping, 1);
    for (int i = 8; i < 17; i++) send(100, ramp_exp[i], 1'b0);
    drain("drain_ramp_up");
    chk("ramp_end_gain", bus.gain_current, 32);
    chk("ramp_end_ramping", bus.ramping, 0);

    // Ramp down, retarget to 10 at gain 20; data 160 gives output 10*gain
    load_tgt(0);
    for (int i = 0; i < 12; i++) send(160, 10 * (32 - i), 1'b0);
    chk("retarget_at_20", bus.gain_current, 20);
    send(160, 200, 1'b0, 1'b1, 10);
    for (int g = 19; g >= 11; g--) send(160, 10 * g, 1'b0);
    drain("drain_ramp_down");
    chk("down_end_gain", bus.gain_current, 10);
    chk("down_end_ramping", bus.ramping, 0);

    // Load coincident with a sample in HOLD: no step for that sample
    send(160, 100, 1'b0, 1'b1, 30);
    bus.data_valid = 1'b0;
    bus.gain_load  = 1'b0;
    chk("coinc_gain_held", bus.gain_current, 10);
    chk("coinc_ramping", bus.ramping, 1);
    send(160, 100, 1'b0);
    bus.data_valid = 1'b0;
    chk("coinc_next_step", bus.gain_current, 11);

    // Reset mid-ramp with samples in flight
    send(160, 110, 1'b0);
    send(160, 120, 1'b0);
    bus.data_valid = 1'b0;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_gain", bus.gain_current, 16);
    chk("mid_rst_ramping", bus.ramping, 0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // Rounding at gain 8
    load_tgt(8);
    repeat (8) send(0, 0, 1'b0);
    chk("round_gain", bus.gain_current, 8);
    send(1, 1, 1'b0);
    send(-1, 0, 1'b0);
    send(3, 2, 1'b0);
    send(-3, -1, 1'b0);
    drain("drain_round");

    // Saturation at gain 255
    load_tgt(255);
    repeat (247) send(0, 0, 1'b0);
    drain("drain_ramp_255");
    chk("sat_gain", bus.gain_current, 255);
    chk("sat_ramping", bus.ramping, 0);
    send(32767, 32767, 1'b1);
    send(-32768, -32768, 1'b1);
    send(128, 2040, 1'b0);
    send(32767, 32767, 1'b1);
    drain("drain_sat");
    idle(3);
    chk("hold_data_out", bus.data_out, 32767);
    chk("hold_clip", bus.clip, 1);
    chk("clip_count", bus.clip_count, exp_clip_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_band_gain.md
Name: eq_band_gain

Overview:
Per-band gain stage directly downstream of the 32-tap low-pass FIR in the equalizer datapath. It consumes the FIR's 16-bit signed filtered samples and applies a programmable unsigned fixed-point gain. The gain ramps toward its target one LSB per sample to avoid zipper noise. Results are rounded and saturated back to 16 bits for the band summer, with a 2-cycle valid-tagged pipeline.

Parameters:
word_size_in, 16, width of signed input sample (FIR output width, 2x FIR input width)
word_size_out, 16, width of signed output sample
gain_width, 8, width of unsigned gain code
gain_frac, 4, fractional bits of gain (unity = 1<<gain_frac = 16)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  word_size_in  signed filtered sample from FIR
data_valid  input  1  data_in valid this cycle
gain_target  input  gain_width  requested gain code
gain_load  input  1  latch gain_target this cycle
data_out  output  word_size_out  signed gained, rounded, saturated sample
out_valid  output  1  data_out valid this cycle
clip  output  1  data_out was saturated (qualified by out_valid)
gain_current  output  gain_width  gain code currently applied
ramping  output  1  gain_current != registered target
clip_count  output  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset (async, active-high): data_out=0, out_valid=0, clip=0, clip_count=0, pipeline valids cleared, target register=16, gain_current=16, ramping=0, FSM=HOLD. Reset mid-ramp or mid-pipeline discards all in-flight samples.
- Target register: loads gain_target on a clk edge with gain_load=1. A repeated load overwrites the target; the ramp redirects from the present gain_current.
- FSM states: HOLD (gain_current==target), RAMP_UP (gain_current<target), RAMP_DOWN (gain_current>target). State is re-evaluated every cycle from the registered target.
- Stepping: only on cycles with data_valid=1. RAMP_UP adds 1 and RAMP_DOWN subtracts 1 to gain_current. HOLD makes no change. No step without valid samples.
- Sample N in cycle t is multiplied by the gain_current value held during cycle t, which is the pre-step value. The step takes effect at the edge ending cycle t.
- Simultaneous gain_load and data_valid: that cycle's step compares against the old target; the new target governs from the next cycle.
- Stage 1 (edge after data_valid): product = data_in * signed{1'b0,gain_current}, full precision, word_size_in+gain_width+1 bits (25). Valid propagates.
- Stage 2: add 1<<(gain_frac-1), arithmetic shift right by gain_frac (round half toward +inf). Saturate to [-2^(word_size_out-1), 2^(word_size_out-1)-1]. Set clip=1 if saturated.
- Latency: data_valid at cycle t produces out_valid=1 in cycle t+2. Full throughput: one sample per cycle with back-to-back valids.
- When out_valid=0, data_out and clip hold their last values.
- gain_current=0 gives output 0. Gain 255 gives 15.9375x.
- ramping = (FSM != HOLD), registered.

Optional Feature:
Macro EQ_GAIN_CLIP_COUNT_EN.
- Defined: clip_count increments on each cycle with out_valid=1 and clip=1, saturating at 65535 (no wrap). It clears only on reset.
- Undefined: no counter logic; clip_count is tied to 0. The port is always present.

Test Plan:
- Reset then idle -> data_out=0, out_valid=0, gain_current=16, ramping=0; assert reset mid-stream -> out_valid drops immediately, gain_current returns to 16.
- Unity gain, data_in=1000 valid at cycle t -> data_out=1000, out_valid=1 at t+2; back-to-back -1000,7 -> -1000,7 on consecutive cycles.
- gain_load target=32, then valid samples of 100 -> outputs 100, 106, 113, ... Gain reaches 32 on the 17th sample, output 200, ramping falls to 0. Gaps in data_valid freeze the ramp.
- Mid-ramp retarget to 10 while gain_current=20 -> steps down 19, 18, ... to 10; load coincident with a valid step uses the old target for that step.
- Rounding at gain=8: data_in=1 -> 1, data_in=-1 -> 0, data_in=3 -> 2, data_in=-3 -> -1.
- Saturation at gain=255: 32767 -> 32767 with clip=1; -32768 -> -32768 with clip=1; 128 -> 2040 with clip=0. With EQ_GAIN_CLIP_COUNT_EN, 3 clipped samples -> clip_count=3.
